// File: rtl/mem_port_arbiter.sv
// Two-requester round-robin arbiter for one single-ported synchronous memory.
// Optional per-requester stall counters are compiled in with MEM_ARB_PERF_CNT_EN.
module mem_port_arbiter #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              r0_en,
   input  logic              r0_we,
   input  logic [ADDR_W-1:0] r0_addr,
   input  logic [DATA_W-1:0] r0_wr_data,
   input  logic              r1_en,
   input  logic              r1_we,
   input  logic [ADDR_W-1:0] r1_addr,
   input  logic [DATA_W-1:0] r1_wr_data,
   output logic              r0_gnt,
   output logic              r1_gnt,
   output logic              r0_rd_valid,
   output logic              r1_rd_valid,
   output logic [DATA_W-1:0] r0_rd_data,
   output logic [DATA_W-1:0] r1_rd_data,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wr_data,
   input  logic [DATA_W-1:0] mem_rd_data
`ifdef MEM_ARB_PERF_CNT_EN
   ,
   output logic [31:0]       r0_stall_cnt,
   output logic [31:0]       r1_stall_cnt
`endif
);

   // last_gnt = 1 means r1 was served last, so r0 wins the next conflict.
   logic last_gnt;
   logic gnt0;
   logic gnt1;
   logic vld_p1;
   logic owner_p1;

   // Grant is combinational; requests are ignored while reset is held low.
   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      if (rst) begin
         if (r0_en && r1_en) begin
            gnt0 = last_gnt;
            gnt1 = ~last_gnt;
         end else begin
            gnt0 = r0_en;
            gnt1 = r1_en;
         end
      end
   end

   assign r0_gnt = gnt0;
   assign r1_gnt = gnt1;

   always_comb begin
      mem_en      = gnt0 | gnt1;
      mem_we      = 1'b0;
      mem_addr    = '0;
      mem_wr_data = '0;
      if (gnt0) begin
         mem_we      = r0_we;
         mem_addr    = r0_addr;
         mem_wr_data = r0_wr_data;
      end else if (gnt1) begin
         mem_we      = r1_we;
         mem_addr    = r1_addr;
         mem_wr_data = r1_wr_data;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         last_gnt <= 1'b1;
      end else if (gnt0 || gnt1) begin
         last_gnt <= gnt1;
      end
   end

   // ---- stage p1: read tag, aligned with the memory's one-cycle read latency
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         vld_p1   <= 1'b0;
         owner_p1 <= 1'b0;
      end else begin
         vld_p1   <= mem_en & ~mem_we;
         owner_p1 <= gnt1;
      end
   end

   assign r0_rd_valid = vld_p1 & ~owner_p1;
   assign r1_rd_valid = vld_p1 &  owner_p1;
   assign r0_rd_data  = r0_rd_valid ? mem_rd_data : '0;
   assign r1_rd_data  = r1_rd_valid ? mem_rd_data : '0;

`ifdef MEM_ARB_PERF_CNT_EN
   function automatic logic [31:0] sat_inc(input logic [31:0] cnt);
      return (cnt == '1) ? cnt : cnt + 32'd1;
   endfunction

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r0_stall_cnt <= '0;
         r1_stall_cnt <= '0;
      end else begin
         if (r0_en && !gnt0) r0_stall_cnt <= sat_inc(r0_stall_cnt);
         if (r1_en && !gnt1) r1_stall_cnt <= sat_inc(r1_stall_cnt);
      end
   end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: per-cycle vector table with a
// read-return scoreboard and a behavioural one-cycle-latency memory.
module tb_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        r0_en = 0, r0_we = 0, r1_en = 0, r1_we = 0;
   logic [7:0]  r0_addr = 0, r1_addr = 0;
   logic [31:0] r0_wr_data = 0, r1_wr_data = 0;
   logic        r0_gnt, r1_gnt, r0_rd_valid, r1_rd_valid;
   logic [31:0] r0_rd_data, r1_rd_data;
   logic        mem_en, mem_we;
   logic [7:0]  mem_addr;
   logic [31:0] mem_wr_data;
   logic [31:0] mem_rd_data;
`ifdef MEM_ARB_PERF_CNT_EN
   logic [31:0] r0_stall_cnt, r1_stall_cnt;
   logic [31:0] exp_sc0 = 0, exp_sc1 = 0;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mem_port_arbiter #(.ADDR_W(8), .DATA_W(32)) dut (
      .clk(clk), .rst(rst),
      .r0_en(r0_en), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wr_data(r0_wr_data),
      .r1_en(r1_en), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wr_data(r1_wr_data),
      .r0_gnt(r0_gnt), .r1_gnt(r1_gnt),
      .r0_rd_valid(r0_rd_valid), .r1_rd_valid(r1_rd_valid),
      .r0_rd_data(r0_rd_data), .r1_rd_data(r1_rd_data),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data)
`ifdef MEM_ARB_PERF_CNT_EN
      , .r0_stall_cnt(r0_stall_cnt), .r1_stall_cnt(r1_stall_cnt)
`endif
   );

   function automatic logic [31:0] init_word(input int a);
      return (a == 5) ? 32'hDEADBEEF : (32'hC0DE0000 | 32'(a));
   endfunction

   // Behavioural memory: synchronous write, one-cycle registered read.
   logic [31:0] mem [256];
   initial begin
      mem_rd_data = '0;
      for (int i = 0; i < 256; i++) mem[i] = init_word(i);
      forever begin
         @(posedge clk);
         if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wr_data;
            else        mem_rd_data   <= mem[mem_addr];
         end
      end
   end

   typedef struct {
      logic        rst;
      logic        e0, w0;
      logic [7:0]  a0;
      logic [31:0] d0;
      logic        e1, w1;
      logic [7:0]  a1;
      logic [31:0] d1;
      logic        g0, g1;
   } vec_t;

   typedef struct {
      logic        v0, v1;
      logic [31:0] d;
   } rd_exp_t;

   vec_t        tbl[$];
   rd_exp_t     sb[$];
   logic [31:0] ref_mem [256];

   function automatic vec_t mk(input logic rs, input logic e0, input logic w0,
                               input logic [7:0] a0, input logic [31:0] d0,
                               input logic e1, input logic w1,
                               input logic [7:0] a1, input logic [31:0] d1,
                               input logic g0, input logic g1);
      vec_t v;
      v.rst = rs; v.e0 = e0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
      v.e1 = e1; v.w1 = w1; v.a1 = a1; v.d1 = d1; v.g0 = g0; v.g1 = g1;
      return v;
   endfunction

   task automatic chk(input string nm, input int idx, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s[%0d] actual=%h required=%h", nm, idx, act, exp);
      end
   endtask

   task automatic step(input vec_t v, input int idx);
      rd_exp_t     e;
      rd_exp_t     nx;
      logic        x_we;
      logic [7:0]  x_addr;
      logic [31:0] x_wd;
      @(negedge clk);
      rst = v.rst;
      r0_en = v.e0; r0_we = v.w0; r0_addr = v.a0; r0_wr_data = v.d0;
      r1_en = v.e1; r1_we = v.w1; r1_addr = v.a1; r1_wr_data = v.d1;
      if (!v.rst) begin
         sb.delete();
         sb.push_back('{1'b0, 1'b0, 32'h0});
      end
      #1;
      chk("r0_gnt", idx, {31'h0, r0_gnt}, {31'h0, v.g0});
      chk("r1_gnt", idx, {31'h0, r1_gnt}, {31'h0, v.g1});
      x_we   = v.g0 ? v.w0 : (v.g1 ? v.w1 : 1'b0);
      x_addr = v.g0 ? v.a0 : (v.g1 ? v.a1 : 8'h0);
      x_wd   = v.g0 ? v.d0 : (v.g1 ? v.d1 : 32'h0);
      chk("mem_en", idx, {31'h0, mem_en}, {31'h0, v.g0 | v.g1});
      chk("mem_we", idx, {31'h0, mem_we}, {31'h0, x_we});
      chk("mem_addr", idx, {24'h0, mem_addr}, {24'h0, x_addr});
      chk("mem_wr_data", idx, mem_wr_data, x_wd);
      if (sb.size() == 0) begin
         checks++; errors++;
         $display("FAIL scoreboard_empty[%0d] actual=0 required=1", idx);
      end else begin
         e = sb.pop_front();
         chk("r0_rd_valid", idx, {31'h0, r0_rd_valid}, {31'h0, e.v0});
         chk("r1_rd_valid", idx, {31'h0, r1_rd_valid}, {31'h0, e.v1});
         chk("r0_rd_data", idx, r0_rd_data, e.v0 ? e.d : 32'h0);
         chk("r1_rd_data", idx, r1_rd_data, e.v1 ? e.d : 32'h0);
      end
`ifdef MEM_ARB_PERF_CNT_EN
      chk("r0_stall_cnt", idx, r0_stall_cnt, exp_sc0);
      chk("r1_stall_cnt", idx, r1_stall_cnt, exp_sc1);
      if (!v.rst) begin
         exp_sc0 = 0; exp_sc1 = 0;
      end else begin
         if (v.e0 && !v.g0) exp_sc0++;
         if (v.e1 && !v.g1) exp_sc1++;
      end
`endif
      nx = '{1'b0, 1'b0, 32'h0};
      if (v.g0 && !v.w0) nx = '{1'b1, 1'b0, ref_mem[v.a0]};
      if (v.g1 && !v.w1) nx = '{1'b0, 1'b1, ref_mem[v.a1]};
      if (v.g0 && v.w0) ref_mem[v.a0] = v.d0;
      if (v.g1 && v.w1) ref_mem[v.a1] = v.d1;
      sb.push_back(nx);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      vec_t idle;
      for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
      idle = mk(1, 0,0,0,0, 0,0,0,0, 0,0);

      // Main vector table, starting right after reset release.
      tbl.push_back(idle);
      tbl.push_back(mk(1, 1,0,8'h01,0, 1,0,8'h02,0, 1,0));   // first conflict: r0 wins
      tbl.push_back(mk(1, 0,0,0,0,     1,0,8'h02,0, 0,1));
      tbl.push_back(idle);
      tbl.push_back(mk(1, 1,0,8'h05,0, 0,0,0,0,     1,0));   // solo read of 0xDEADBEEF
      tbl.push_back(idle);
      tbl.push_back(mk(1, 0,0,0,0,     1,0,8'h30,0, 0,1));
      for (int p = 0; p < 4; p++) begin                      // 8-cycle sustained conflict
         tbl.push_back(mk(1, 1,0,8'(8'h10 + p),0,     1,0,8'(8'h20 + p),0, 1,0));
         tbl.push_back(mk(1, 1,0,8'(8'h10 + p + 1),0, 1,0,8'(8'h20 + p),0, 0,1));
      end
      tbl.push_back(idle);
      tbl.push_back(mk(1, 0,0,0,0, 1,1,8'hFF,32'h12345678, 0,1));  // write then read back
      tbl.push_back(mk(1, 0,0,0,0, 1,0,8'hFF,0,            0,1));
      tbl.push_back(idle);
      tbl.push_back(mk(1, 1,0,8'h07,0, 1,0,8'h08,0, 1,0));   // r1 loses then drops
      tbl.push_back(idle);
      tbl.push_back(idle);
      tbl.push_back(mk(1, 1,1,8'h40,32'hAAAA5555, 1,1,8'h41,32'h5555AAAA, 0,1));
      tbl.push_back(mk(1, 1,1,8'h40,32'hAAAA5555, 0,0,0,0,                1,0));
      tbl.push_back(mk(1, 1,0,8'h40,0, 1,0,8'h41,0, 0,1));
      tbl.push_back(mk(1, 1,0,8'h40,0, 0,0,0,0,     1,0));
      tbl.push_back(idle);

      // Reset state: requests present but ignored while rst is low.
      step(mk(0, 1,0,8'h01,0, 1,1,8'h02,32'h1, 0,0), 1000);
      step(mk(0, 1,1,8'h03,32'h9, 1,0,8'h04,0, 0,0), 1001);

      for (int i = 0; i < tbl.size(); i++) step(tbl[i], i);

      // Reset one cycle after an r0 read grant: no rd_valid, r0 wins next conflict.
      step(mk(1, 1,0,8'h03,0, 0,0,0,0,     1,0), 2000);
      step(mk(0, 1,0,8'h04,0, 1,0,8'h06,0, 0,0), 2001);
      step(mk(0, 1,0,8'h04,0, 1,0,8'h06,0, 0,0), 2002);
      step(mk(1, 1,0,8'h04,0, 1,0,8'h06,0, 1,0), 2003);
      step(mk(1, 0,0,0,0,     1,0,8'h06,0, 0,1), 2004);
      step(idle, 2005);
      step(idle, 2006);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
